// File: rtl/sdram_model.sv
// SDR SDRAM device responder: decodes RAS#/CAS#/WE#, tracks bank/row/mode state,
// services single-word reads at CAS latency and writes, and latches the first protocol violation.
module sdram_model #(
    parameter int BANKBITS = 1,
    parameter int ROWBITS  = 11,
    parameter int COLBITS  = 8,
    parameter int DWIDTH   = 16,
    parameter int T_RCD    = 3,
    parameter int T_RP     = 3,
    parameter int T_RC     = 8,
    parameter int T_MRD    = 3
) (
    input  logic                          clk,
    input  logic                          reset_n,
    input  logic                          pin_ras_n,
    input  logic                          pin_cas_n,
    input  logic                          pin_we_n,
    input  logic [ROWBITS+BANKBITS-1:0]   pin_addr,
    input  logic [DWIDTH-1:0]             pin_data_i,
    output logic [DWIDTH-1:0]             pin_data_o,
    output logic                          pin_data_oe,
    output logic                          ready,
    output logic                          err,
    output logic [3:0]                    err_code
);
    localparam int AWIDTH = ROWBITS + BANKBITS;
    localparam int NBANK  = 1 << BANKBITS;
    localparam int MWIDTH = ROWBITS + BANKBITS + COLBITS;
    localparam int CW     = 8;

    typedef enum logic [2:0] {
        CMD_MRS  = 3'b000,
        CMD_REF  = 3'b001,
        CMD_PRE  = 3'b010,
        CMD_ACT  = 3'b011,
        CMD_WR   = 3'b100,
        CMD_RD   = 3'b101,
        CMD_STOP = 3'b110,
        CMD_NOP  = 3'b111
    } cmd_e;

    cmd_e cmd;
    assign cmd = cmd_e'({pin_ras_n, pin_cas_n, pin_we_n});

    logic [NBANK-1:0]               act_q, act_d;
    logic [NBANK-1:0][ROWBITS-1:0]  row_q, row_d;
    logic [NBANK-1:0][CW-1:0]       bcnt_q, bcnt_d;
    logic [CW-1:0]                  gcnt_q, gcnt_d;
    logic                           gmrd_q, gmrd_d;
    logic                           ready_q, ready_d;
    logic                           cl3_q, cl3_d;
    logic [1:0]                     pv_q, pv_d;
    logic [1:0][DWIDTH-1:0]         pd_q, pd_d;
    logic [DWIDTH-1:0]              dout_q, dout_d;
    logic                           oe_q, oe_d;
    logic                           err_q, err_d;
    logic [3:0]                     code_q, code_d;

    logic [DWIDTH-1:0] mem [2**MWIDTH];

    logic [BANKBITS-1:0] bank;
    logic [ROWBITS-1:0]  arow;
    logic [COLBITS-1:0]  col;
    logic [MWIDTH-1:0]   maddr;
    logic                a10, rw, mode_ok, trp_busy_any, mem_we;
    logic [3:0]          viol;

    assign bank    = pin_addr[AWIDTH-1:ROWBITS];
    assign arow    = pin_addr[ROWBITS-1:0];
    assign col     = pin_addr[COLBITS-1:0];
    assign a10     = pin_addr[10];
    assign maddr   = {row_q[bank], bank, col};
    assign rw      = (cmd == CMD_RD) || (cmd == CMD_WR);
    assign mode_ok = ((pin_addr[6:4] == 3'd2) || (pin_addr[6:4] == 3'd3)) && (pin_addr[2:0] == 3'd0);

    // A bank's counter means tRP while idle and tRCD while active.
    always_comb begin
        trp_busy_any = 1'b0;
        for (int b = 0; b < NBANK; b++)
            if (!act_q[b] && bcnt_q[b] != '0) trp_busy_any = 1'b1;
    end

    always_comb begin
        viol = 4'd0;
        if ((cmd == CMD_ACT || rw) && !ready_q)                            viol = 4'd6;
        else if (cmd != CMD_NOP && gcnt_q != '0 && gmrd_q)                 viol = 4'd10;
        else if (cmd != CMD_NOP && gcnt_q != '0)                           viol = 4'd7;
        else if ((cmd == CMD_ACT && !act_q[bank] && bcnt_q[bank] != '0) ||
                 (cmd == CMD_REF && trp_busy_any))                         viol = 4'd4;
        else if (cmd == CMD_ACT && act_q[bank])                            viol = 4'd1;
        else if (rw && !act_q[bank])                                       viol = 4'd2;
        else if (rw && bcnt_q[bank] != '0)                                 viol = 4'd3;
        else if (cmd == CMD_REF && (|act_q))                               viol = 4'd5;
        else if (cmd == CMD_WR && ((|pv_q) || oe_q))                       viol = 4'd8;
        else if (cmd == CMD_MRS && !mode_ok)                               viol = 4'd9;
    end

    always_comb begin
        act_d   = act_q;
        row_d   = row_q;
        gmrd_d  = gmrd_q;
        ready_d = ready_q;
        cl3_d   = cl3_q;
        err_d   = err_q;
        code_d  = code_q;
        mem_we  = 1'b0;
        for (int b = 0; b < NBANK; b++)
            bcnt_d[b] = (bcnt_q[b] != '0) ? bcnt_q[b] - 1'b1 : '0;
        gcnt_d = (gcnt_q != '0) ? gcnt_q - 1'b1 : '0;
        // Read pipe: slot 0 feeds the output register; CL3 enters at slot 1, CL2 at slot 0.
        pv_d    = {1'b0, pv_q[1]};
        pd_d[1] = pd_q[1];
        pd_d[0] = pd_q[1];
        oe_d    = pv_q[0];
        dout_d  = pv_q[0] ? pd_q[0] : dout_q;

        if (viol != 4'd0 && !err_q) begin
            err_d  = 1'b1;
            code_d = viol;
        end

        if (viol == 4'd0) begin
            case (cmd)
                CMD_MRS: begin
                    ready_d = 1'b1;
                    cl3_d   = (pin_addr[6:4] == 3'd3);
                    gcnt_d  = CW'(T_MRD - 1);
                    gmrd_d  = 1'b1;
                end
                CMD_REF: begin
                    gcnt_d = CW'(T_RC - 1);
                    gmrd_d = 1'b0;
                end
                CMD_PRE: begin
                    for (int b = 0; b < NBANK; b++)
                        if (a10 || BANKBITS'(b) == bank) begin
                            act_d[b]  = 1'b0;
                            bcnt_d[b] = CW'(T_RP - 1);
                        end
                end
                CMD_ACT: begin
                    act_d[bank]  = 1'b1;
                    row_d[bank]  = arow;
                    bcnt_d[bank] = CW'(T_RCD - 1);
                end
                CMD_WR: mem_we = 1'b1;
                CMD_RD: begin
                    if (cl3_q) begin
                        pv_d[1] = 1'b1;
                        pd_d[1] = mem[maddr];
                    end else begin
                        pv_d[0] = 1'b1;
                        pd_d[0] = mem[maddr];
                    end
                end
                default: ;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (mem_we) mem[maddr] <= pin_data_i;
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            act_q   <= '0;
            row_q   <= '0;
            bcnt_q  <= '0;
            gcnt_q  <= '0;
            gmrd_q  <= 1'b0;
            ready_q <= 1'b0;
            cl3_q   <= 1'b1;
            pv_q    <= '0;
            pd_q    <= '0;
            dout_q  <= '0;
            oe_q    <= 1'b0;
            err_q   <= 1'b0;
            code_q  <= '0;
        end else begin
            act_q   <= act_d;
            row_q   <= row_d;
            bcnt_q  <= bcnt_d;
            gcnt_q  <= gcnt_d;
            gmrd_q  <= gmrd_d;
            ready_q <= ready_d;
            cl3_q   <= cl3_d;
            pv_q    <= pv_d;
            pd_q    <= pd_d;
            dout_q  <= dout_d;
            oe_q    <= oe_d;
            err_q   <= err_d;
            code_q  <= code_d;
        end
    end

    assign pin_data_o  = dout_q;
    assign pin_data_oe = oe_q;
    assign ready       = ready_q;
    assign err         = err_q;
    assign err_code    = code_q;
endmodule

// File: tb/tb_sdram_model.sv
// Directed bench for sdram_model: commands driven on the falling edge, outputs checked 1ns after the rising edge.
module tb_sdram_model;
    localparam logic [2:0] MRS = 3'b000, REF = 3'b001, PRE = 3'b010, ACT = 3'b011,
                           WR  = 3'b100, RD  = 3'b101, NOP = 3'b111;

    logic        clk = 1'b0;
    logic        reset_n = 1'b0;
    logic        ras_n = 1'b1, cas_n = 1'b1, we_n = 1'b1;
    logic [11:0] addr = '0;
    logic [15:0] din = '0;
    logic [15:0] dout;
    logic        oe, ready, err;
    logic [3:0]  code;
    int          n_cmp = 0;
    int          n_err = 0;

    sdram_model dut (
        .clk(clk), .reset_n(reset_n),
        .pin_ras_n(ras_n), .pin_cas_n(cas_n), .pin_we_n(we_n),
        .pin_addr(addr), .pin_data_i(din),
        .pin_data_o(dout), .pin_data_oe(oe),
        .ready(ready), .err(err), .err_code(code)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Drive one command; returns 1ns after the rising edge that samples it.
    task automatic issue(input logic [2:0] c, input logic [11:0] a, input logic [15:0] d);
        @(negedge clk);
        {ras_n, cas_n, we_n} = c;
        addr = a;
        din  = d;
        @(posedge clk);
        #1;
    endtask

    task automatic nop();
        issue(NOP, 12'h000, 16'h0000);
    endtask

    task automatic do_reset();
        @(negedge clk);
        {ras_n, cas_n, we_n} = NOP;
        reset_n = 1'b0;
        @(negedge clk);
        @(negedge clk);
        reset_n = 1'b1;
        #1;
    endtask

    task automatic chk_rd(input string tag, input logic exp_oe, input logic [15:0] exp_d);
        chk({tag, "_oe"}, {31'd0, oe}, {31'd0, exp_oe});
        if (exp_oe) chk({tag, "_data"}, {16'd0, dout}, {16'd0, exp_d});
    endtask

    initial begin
        // Reset state
        do_reset();
        chk("rst_oe", {31'd0, oe}, 32'd0);
        chk("rst_dout", {16'd0, dout}, 32'd0);
        chk("rst_ready", {31'd0, ready}, 32'd0);
        chk("rst_err", {31'd0, err}, 32'd0);
        chk("rst_code", {28'd0, code}, 32'd0);

        // Init CL3, write and read back
        issue(MRS, 12'h030, 16'h0);
        chk("mrs_ready", {31'd0, ready}, 32'd1);
        chk("mrs_err", {31'd0, err}, 32'd0);
        nop(); nop();
        issue(ACT, 12'h155, 16'h0);
        nop(); nop();
        issue(WR, 12'h012, 16'hBEEF);
        issue(WR, 12'h000, 16'hA5A5);
        issue(RD, 12'h012, 16'h0);
        chk_rd("cl3_r0", 1'b0, 16'h0);
        nop();  chk_rd("cl3_r1", 1'b0, 16'h0);
        nop();  chk_rd("cl3_r2", 1'b1, 16'hBEEF);
        nop();  chk_rd("cl3_r3", 1'b0, 16'h0);
        chk("cl3_hold", {16'd0, dout}, {16'd0, 16'hBEEF});

        // Bank isolation, write-then-read, back-to-back reads
        issue(ACT, 12'h807, 16'h0);
        nop(); nop();
        issue(WR, 12'h800, 16'h1234);
        issue(RD, 12'h800, 16'h0);
        issue(RD, 12'h000, 16'h0);
        nop();  chk_rd("iso_b1", 1'b1, 16'h1234);
        nop();  chk_rd("iso_b0", 1'b1, 16'hA5A5);
        nop();  chk_rd("iso_end", 1'b0, 16'h0);
        chk("iso_err", {31'd0, err}, 32'd0);

        // tRCD violation discards the write; later legal read sees old data
        issue(PRE, 12'h000, 16'h0);
        nop(); nop();
        issue(ACT, 12'h155, 16'h0);
        nop();
        issue(WR, 12'h012, 16'hDEAD);
        chk("trcd_err", {31'd0, err}, 32'd1);
        chk("trcd_code", {28'd0, code}, 32'd3);
        issue(RD, 12'h012, 16'h0);
        nop();  chk_rd("trcd_r1", 1'b0, 16'h0);
        nop();  chk_rd("trcd_r2", 1'b1, 16'hBEEF);
        issue(ACT, 12'h155, 16'h0);
        chk("sticky_code", {28'd0, code}, 32'd3);

        // REFRESH with a bank active
        do_reset();
        issue(MRS, 12'h030, 16'h0);
        nop(); nop();
        issue(ACT, 12'h155, 16'h0);
        nop();
        issue(REF, 12'h000, 16'h0);
        chk("ref_act_code", {28'd0, code}, 32'd5);

        // Precharge-all then REFRESH is legal; command inside tRC is not
        do_reset();
        issue(MRS, 12'h030, 16'h0);
        nop(); nop();
        issue(ACT, 12'h155, 16'h0);
        issue(ACT, 12'h807, 16'h0);
        issue(PRE, 12'h400, 16'h0);
        nop(); nop();
        issue(REF, 12'h000, 16'h0);
        chk("ref_ok_err", {31'd0, err}, 32'd0);
        nop();
        issue(ACT, 12'h155, 16'h0);
        chk("trc_code", {28'd0, code}, 32'd7);

        // CL2: single read, four back-to-back reads, then bus conflict
        do_reset();
        issue(MRS, 12'h020, 16'h0);
        nop(); nop();
        issue(ACT, 12'h155, 16'h0);
        nop(); nop();
        issue(WR, 12'h001, 16'h1111);
        issue(WR, 12'h002, 16'h2222);
        issue(RD, 12'h012, 16'h0);
        chk_rd("cl2_r0", 1'b0, 16'h0);
        nop();  chk_rd("cl2_r1", 1'b1, 16'hBEEF);
        nop();  chk_rd("cl2_r2", 1'b0, 16'h0);
        issue(RD, 12'h000, 16'h0);
        issue(RD, 12'h001, 16'h0);  chk_rd("b2b_0", 1'b1, 16'hA5A5);
        issue(RD, 12'h002, 16'h0);  chk_rd("b2b_1", 1'b1, 16'h1111);
        issue(RD, 12'h012, 16'h0);  chk_rd("b2b_2", 1'b1, 16'h2222);
        nop();  chk_rd("b2b_3", 1'b1, 16'hBEEF);
        nop();  chk_rd("b2b_end", 1'b0, 16'h0);
        chk("cl2_err", {31'd0, err}, 32'd0);
        issue(RD, 12'h000, 16'h0);
        issue(WR, 12'h001, 16'h5555);
        chk("conflict_code", {28'd0, code}, 32'd8);
        chk_rd("conflict_rd", 1'b1, 16'hA5A5);

        // Command before ready
        do_reset();
        issue(ACT, 12'h155, 16'h0);
        chk("notready_code", {28'd0, code}, 32'd6);

        // Bad mode word
        do_reset();
        issue(MRS, 12'h031, 16'h0);
        chk("badmode_code", {28'd0, code}, 32'd9);
        chk("badmode_ready", {31'd0, ready}, 32'd0);

        // tMRD violation
        do_reset();
        issue(MRS, 12'h030, 16'h0);
        nop();
        issue(ACT, 12'h155, 16'h0);
        chk("tmrd_code", {28'd0, code}, 32'd10);

        // tRP violation on ACTIVE
        do_reset();
        issue(MRS, 12'h030, 16'h0);
        nop(); nop();
        issue(PRE, 12'h000, 16'h0);
        nop();
        issue(ACT, 12'h155, 16'h0);
        chk("trp_code", {28'd0, code}, 32'd4);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule
